// File: rtl/imm_encoder_if.sv
// imm_encoder_if: valid/ready request and response channels of the immediate encoder.
//   in_valid  : request present (master -> slave)
//   in_ready  : encoder can accept a request (slave -> master)
//   in_value  : 32-bit target value to encode
//   in_eop    : extender op the immediate is meant for
//   out_valid : response head valid (slave -> master)
//   out_ready : consumer takes the head (master -> slave)
//   out_imm   : encoded 16-bit immediate
//   out_eop   : echo of the request EOp
//   out_err   : value not representable under out_eop
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [1:0]  in_eop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_err;
    modport master (
        output in_valid, in_value, in_eop, out_ready,
        input  in_ready, out_valid, out_imm, out_eop, out_err
    );
    modport slave (
        input  in_valid, in_value, in_eop, out_ready,
        output in_ready, out_valid, out_imm, out_eop, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: inverts the immediate extender, producing the 16-bit immediate that
// expands back to a 32-bit target under a given EOp, with a representability flag.
// Results are queued in a 2-entry FIFO behind a valid/ready handshake.
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset, discards all queued entries
//   bus         : imm_encoder_if.slave request/response channels
//   o_err_count : saturating count of accepted entries flagged as errors
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] o_err_count
);
    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        err;
    } entry_t;
    entry_t           r_mem [2];
    entry_t           r_last;
    entry_t           w_new;
    entry_t           w_head;
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_cnt;
    logic [CNT_W-1:0] r_err_count;
    logic [31:0]      w_v;
    logic             w_sx15;
    logic             w_sx17;
    logic             w_push;
    logic             w_pop;
    assign w_v    = bus.in_value;
    // Upper bits must be a pure sign extension of the top immediate bit.
    assign w_sx15 = (&w_v[31:15]) | ~(|w_v[31:15]);
    assign w_sx17 = (&w_v[31:17]) | ~(|w_v[31:17]);
    always_comb begin
        w_new.eop = bus.in_eop;
        w_new.imm = bus.in_eop == 2'b10 ? w_v[31:16] :
                    bus.in_eop == 2'b11 ? w_v[17:2]  : w_v[15:0];
        w_new.err = bus.in_eop == 2'b00 ? ~w_sx15 :
                    bus.in_eop == 2'b01 ? |w_v[31:16] :
                    bus.in_eop == 2'b10 ? |w_v[15:0] : (|w_v[1:0]) | ~w_sx17;
    end
    assign bus.in_ready  = ~r_cnt[1];
    assign bus.out_valid = |r_cnt;
    assign w_push        = bus.in_valid & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;
    // An empty FIFO shows the most recently popped entry rather than a stale slot.
    assign w_head        = bus.out_valid ? r_mem[r_rp] : r_last;
    assign bus.out_imm   = w_head.imm;
    assign bus.out_eop   = w_head.eop;
    assign bus.out_err   = w_head.err;
    assign o_err_count   = r_err_count;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_last      <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_cnt       <= 2'd0;
            r_err_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_new;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_last <= r_mem[r_rp];
                r_rp   <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push && w_new.err && !(&r_err_count))
                r_err_count <= r_err_count + 1'b1;
        end
    end
endmodule
